life_array_grid: RTL and testbench

- Parametrised successor to the fixed 8x8 Conway cell array: a ROWS x COLS grid of life cells, accessed through 4x4 tiles over a 16-bit port.
- Adds a selectable toroidal (wrap) mode and edge outputs so grids can be tiled.
- Adds a generation counter and registered stable, oscillating and extinct status flags, so the display/controller layer can stop stepping dead or static patterns.

---
 rtl/life_array_grid.sv | 147 ++++++++++++++
 tb/tb_life_array_grid.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_array_grid.sv
// ROWS x COLS Conway life grid (B3/S23). The grid is loaded and read as 4x4 tiles over a
// 16-bit port. It supports an optional toroidal wrap, edge I/O for tiling, and generation status flags.
module life_array_grid #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16,
  parameter int SEL_W = ($clog2((ROWS/4)*(COLS/4)) < 1) ? 1 : $clog2((ROWS/4)*(COLS/4))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      vali,
  input  logic [SEL_W-1:0] vali_selector,
  input  logic [SEL_W-1:0] valo_selector,
  input  logic             write_enb,
  input  logic             step,
  input  logic             wrap,
  input  logic [COLS-1:0]  n,
  input  logic [COLS-1:0]  s,
  input  logic [ROWS-1:0]  w,
  input  logic [ROWS-1:0]  e,
  input  logic             nw,
  input  logic             ne,
  input  logic             se,
  input  logic             sw,
  output logic [15:0]      valo,
  output logic [15:0]      valo_prev,
  output logic [COLS-1:0]  n_out,
  output logic [COLS-1:0]  s_out,
  output logic [ROWS-1:0]  w_out,
  output logic [ROWS-1:0]  e_out,
  output logic [GEN_W-1:0] gen_count,
  output logic             stable,
  output logic             oscillating,
  output logic             extinct
);

  localparam int TILE_ROWS = ROWS / 4;
  localparam int NT        = TILE_ROWS * (COLS / 4);

  logic [ROWS-1:0][COLS-1:0] cur, prev, nxt, wr_cur, wr_prev;
  logic [ROWS+1:0][COLS+1:0] ext;
  logic [15:0]               tile_cur  [NT];
  logic [15:0]               tile_prev [NT];

  // Grid padded by one cell on every side; the ring comes from the opposite edge or the inputs.
  always_comb begin
    ext = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        ext[r+1][c+1] = cur[r][c];
      end
    end
    if (wrap) begin
      for (int c = 0; c < COLS; c++) begin
        ext[0][c+1]      = cur[ROWS-1][c];
        ext[ROWS+1][c+1] = cur[0][c];
      end
      for (int r = 0; r < ROWS; r++) begin
        ext[r+1][0]      = cur[r][COLS-1];
        ext[r+1][COLS+1] = cur[r][0];
      end
      ext[0][0]           = cur[ROWS-1][COLS-1];
      ext[0][COLS+1]      = cur[ROWS-1][0];
      ext[ROWS+1][0]      = cur[0][COLS-1];
      ext[ROWS+1][COLS+1] = cur[0][0];
    end else begin
      for (int c = 0; c < COLS; c++) begin
        ext[0][c+1]      = n[c];
        ext[ROWS+1][c+1] = s[c];
      end
      for (int r = 0; r < ROWS; r++) begin
        ext[r+1][0]      = w[r];
        ext[r+1][COLS+1] = e[r];
      end
      ext[0][0]           = nw;
      ext[0][COLS+1]      = ne;
      ext[ROWS+1][0]      = sw;
      ext[ROWS+1][COLS+1] = se;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      // Tile number and bit position of this cell within its tile.
      localparam int T = (c / 4) * TILE_ROWS + r / 4;
      localparam int B = (c % 4) * 4 + r % 4;
      logic [3:0] cnt;
      logic       hit;
      assign cnt = 4'(ext[r][c])   + 4'(ext[r][c+1])   + 4'(ext[r][c+2]) +
                   4'(ext[r+1][c])                     + 4'(ext[r+1][c+2]) +
                   4'(ext[r+2][c]) + 4'(ext[r+2][c+1]) + 4'(ext[r+2][c+2]);
      assign nxt[r][c]     = (cnt == 4'd3) || (cur[r][c] && (cnt == 4'd2));
      assign hit           = write_enb && (vali_selector == SEL_W'(T));
      assign wr_cur[r][c]  = hit ? vali[B] : cur[r][c];
      assign wr_prev[r][c] = hit ? vali[B] : prev[r][c];
      assign tile_cur[T][B]  = cur[r][c];
      assign tile_prev[T][B] = prev[r][c];
    end
  end

  always_comb begin
    valo      = '0;
    valo_prev = '0;
    if (int'(valo_selector) < NT) begin
      valo      = tile_cur[valo_selector];
      valo_prev = tile_prev[valo_selector];
    end
  end

  assign n_out = cur[0];
  assign s_out = cur[ROWS-1];

  always_comb begin
    w_out = '0;
    e_out = '0;
    for (int r = 0; r < ROWS; r++) begin
      w_out[r] = cur[r][0];
      e_out[r] = cur[r][COLS-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= '0;
      prev        <= '0;
      gen_count   <= '0;
      stable      <= 1'b0;
      oscillating <= 1'b0;
      extinct     <= 1'b1;
    end else if (write_enb) begin
      cur         <= wr_cur;
      prev        <= wr_prev;
      gen_count   <= '0;
      stable      <= 1'b0;
      oscillating <= 1'b0;
      extinct     <= (wr_cur == '0);
    end else if (step) begin
      prev        <= cur;
      cur         <= nxt;
      gen_count   <= gen_count + GEN_W'(1);
      stable      <= (nxt == cur);
      oscillating <= (nxt == prev) && (nxt != cur);
      extinct     <= (nxt == '0);
    end
  end

endmodule

// File: tb/tb_life_array_grid.sv
// Bench for life_array_grid: 8x8 table-driven vectors with a scoreboard queue, plus
// 12x8 sequences for out-of-range selectors, generation wrap and asynchronous reset mid-step.
module tb_life_array_grid;

  localparam logic [1:0] OP_IDLE = 2'd0;
  localparam logic [1:0] OP_WR   = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_RST  = 2'd3;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sel;
    logic [15:0] data;
    logic        wrap;
    logic [1:0]  edge_mode;
    logic [1:0]  chk;
    logic [15:0] exp_valo;
    logic [15:0] exp_prev;
    logic        exp_stable;
    logic        exp_osc;
    logic        exp_ext;
    logic [15:0] exp_gen;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8x8 instance
  logic        rst_a;
  logic [15:0] vali_a;
  logic [1:0]  wsel_a, rsel_a;
  logic        we_a, step_a, wrap_a;
  logic [7:0]  n_a, s_a, w_a, e_a;
  logic        nw_a, ne_a, se_a, sw_a;
  logic [15:0] valo_a, valo_prev_a;
  logic [7:0]  n_out_a, s_out_a, w_out_a, e_out_a;
  logic [15:0] gen_a;
  logic        stable_a, osc_a, ext_a;

  // 12x8 instance with a 4-bit generation counter
  logic        rst_b;
  logic [15:0] vali_b;
  logic [2:0]  wsel_b, rsel_b;
  logic        we_b, step_b;
  logic [7:0]  n_out_b, s_out_b;
  logic [11:0] w_out_b, e_out_b;
  logic [15:0] valo_b, valo_prev_b;
  logic [3:0]  gen_b;
  logic        stable_b, osc_b, ext_b;

  life_array_grid #(.ROWS(8), .COLS(8), .GEN_W(16)) u_dut_a (
    .clk(clk), .reset(rst_a), .vali(vali_a), .vali_selector(wsel_a), .valo_selector(rsel_a),
    .write_enb(we_a), .step(step_a), .wrap(wrap_a),
    .n(n_a), .s(s_a), .w(w_a), .e(e_a), .nw(nw_a), .ne(ne_a), .se(se_a), .sw(sw_a),
    .valo(valo_a), .valo_prev(valo_prev_a),
    .n_out(n_out_a), .s_out(s_out_a), .w_out(w_out_a), .e_out(e_out_a),
    .gen_count(gen_a), .stable(stable_a), .oscillating(osc_a), .extinct(ext_a)
  );

  life_array_grid #(.ROWS(12), .COLS(8), .GEN_W(4)) u_dut_b (
    .clk(clk), .reset(rst_b), .vali(vali_b), .vali_selector(wsel_b), .valo_selector(rsel_b),
    .write_enb(we_b), .step(step_b), .wrap(1'b0),
    .n(8'h00), .s(8'h00), .w(12'h000), .e(12'h000),
    .nw(1'b0), .ne(1'b0), .se(1'b0), .sw(1'b0),
    .valo(valo_b), .valo_prev(valo_prev_b),
    .n_out(n_out_b), .s_out(s_out_b), .w_out(w_out_b), .e_out(e_out_b),
    .gen_count(gen_b), .stable(stable_b), .oscillating(osc_b), .extinct(ext_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [50:0] exp_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] op, input logic [1:0] sel, input logic [15:0] data,
                     input logic wr, input logic [1:0] em, input logic [1:0] chk,
                     input logic [15:0] ev, input logic [15:0] ep, input logic es,
                     input logic eo, input logic ee, input logic [15:0] eg);
    vec_t v;
    v.op = op; v.sel = sel; v.data = data; v.wrap = wr; v.edge_mode = em; v.chk = chk;
    v.exp_valo = ev; v.exp_prev = ep; v.exp_stable = es; v.exp_osc = eo; v.exp_ext = ee;
    v.exp_gen = eg;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_edges_a(input logic [1:0] em);
    n_a = 8'h00; s_a = 8'h00; w_a = 8'h00; e_a = 8'h00;
    {nw_a, ne_a, se_a, sw_a} = 4'b0000;
    if (em == 2'd1) begin
      n_a = 8'hFF; s_a = 8'hFF; w_a = 8'hFF; e_a = 8'hFF;
      {nw_a, ne_a, se_a, sw_a} = 4'b1111;
    end else if (em == 2'd2) begin
      w_a = 8'h07;
    end
  endtask

  task automatic reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    #1 rst_a = 1'b0;
  endtask

  task automatic write_a(input logic [1:0] sel, input logic [15:0] data, input logic wr);
    @(negedge clk);
    wsel_a = sel; vali_a = data; wrap_a = wr; we_a = 1'b1;
    @(posedge clk);
    #1 we_a = 1'b0;
  endtask

  task automatic step_a_once(input logic wr, input logic [1:0] em);
    @(negedge clk);
    wrap_a = wr; set_edges_a(em); step_a = 1'b1;
    @(posedge clk);
    #1 step_a = 1'b0;
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    logic [50:0] exp;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    case (v.op)
      OP_RST:  reset_a();
      OP_WR:   write_a(v.sel, v.data, v.wrap);
      OP_STEP: step_a_once(v.wrap, v.edge_mode);
      default: begin @(posedge clk); #1; end
    endcase
    rsel_a = v.chk;
    exp_q.push_back({v.exp_valo, v.exp_prev, v.exp_stable, v.exp_osc, v.exp_ext, v.exp_gen});
    #1;
    exp = exp_q.pop_front();
    check($sformatf("v%0d valo", idx),      32'(valo_a),      32'(exp[50:35]));
    check($sformatf("v%0d valo_prev", idx), 32'(valo_prev_a), 32'(exp[34:19]));
    check($sformatf("v%0d stable", idx),    32'(stable_a),    32'(exp[18]));
    check($sformatf("v%0d oscillating", idx), 32'(osc_a),     32'(exp[17]));
    check($sformatf("v%0d extinct", idx),   32'(ext_a),       32'(exp[16]));
    check($sformatf("v%0d gen_count", idx), 32'(gen_a),       32'(exp[15:0]));
  endtask

  task automatic check_all_tiles_b_zero(input string tag);
    for (int t = 0; t < 6; t++) begin
      rsel_b = 3'(t);
      #1;
      check($sformatf("%s valo t%0d", tag, t), 32'(valo_b), 32'h0);
      check($sformatf("%s valo_prev t%0d", tag, t), 32'(valo_prev_b), 32'h0);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    rst_a = 1'b1; vali_a = '0; wsel_a = '0; rsel_a = '0; we_a = 1'b0; step_a = 1'b0;
    wrap_a = 1'b0; set_edges_a(2'd0);
    rst_b = 1'b1; vali_b = '0; wsel_b = '0; rsel_b = '0; we_b = 1'b0; step_b = 1'b0;

    // op, sel, data, wrap, edge, chk, valo, valo_prev, stable, osc, extinct, gen
    add(OP_RST,  0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(OP_STEP, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 1);
    // lone cell dies
    add(OP_RST,  0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(OP_WR,   0, 16'h0001, 0, 0, 0, 16'h0001, 16'h0001, 0, 0, 0, 0);
    add(OP_STEP, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0001, 0, 0, 1, 1);
    // block straddling all four tiles
    add(OP_RST,  0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(OP_WR,   0, 16'h8000, 0, 0, 0, 16'h8000, 16'h8000, 0, 0, 0, 0);
    add(OP_WR,   2, 16'h0008, 0, 0, 2, 16'h0008, 16'h0008, 0, 0, 0, 0);
    add(OP_WR,   3, 16'h0001, 0, 0, 3, 16'h0001, 16'h0001, 0, 0, 0, 0);
    add(OP_WR,   1, 16'h1000, 0, 0, 1, 16'h1000, 16'h1000, 0, 0, 0, 0);
    add(OP_STEP, 0, 16'h0000, 0, 0, 0, 16'h8000, 16'h8000, 1, 0, 0, 1);
    add(OP_IDLE, 0, 16'h0000, 0, 0, 1, 16'h1000, 16'h1000, 1, 0, 0, 1);
    add(OP_IDLE, 0, 16'h0000, 0, 0, 2, 16'h0008, 16'h0008, 1, 0, 0, 1);
    add(OP_IDLE, 0, 16'h0000, 0, 0, 3, 16'h0001, 16'h0001, 1, 0, 0, 1);
    // three cells -> pair -> extinct
    add(OP_RST,  0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(OP_WR,   0, 16'h0025, 0, 0, 0, 16'h0025, 16'h0025, 0, 0, 0, 0);
    add(OP_STEP, 0, 16'h0000, 0, 0, 0, 16'h0022, 16'h0025, 0, 0, 0, 1);
    add(OP_STEP, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0022, 0, 0, 1, 2);
    // blinker, then a rewrite clears oscillating and gen_count
    add(OP_RST,  0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(OP_WR,   0, 16'h0070, 0, 0, 0, 16'h0070, 16'h0070, 0, 0, 0, 0);
    add(OP_STEP, 0, 16'h0000, 0, 0, 0, 16'h0222, 16'h0070, 0, 0, 0, 1);
    add(OP_STEP, 0, 16'h0000, 0, 0, 0, 16'h0070, 16'h0222, 0, 1, 0, 2);
    add(OP_STEP, 0, 16'h0000, 0, 0, 0, 16'h0222, 16'h0070, 0, 1, 0, 3);
    add(OP_WR,   0, 16'h0070, 0, 0, 0, 16'h0070, 16'h0070, 0, 0, 0, 0);
    // toroidal: edge inputs driven high must be ignored
    add(OP_RST,  0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(OP_WR,   0, 16'h0007, 1, 1, 0, 16'h0007, 16'h0007, 0, 0, 0, 0);
    add(OP_STEP, 0, 16'h0000, 1, 1, 2, 16'h2000, 16'h0000, 0, 0, 0, 1);
    add(OP_IDLE, 0, 16'h0000, 1, 1, 0, 16'h0022, 16'h0007, 0, 0, 0, 1);
    // bounded grid, same pattern
    add(OP_RST,  0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(OP_WR,   0, 16'h0007, 0, 0, 0, 16'h0007, 16'h0007, 0, 0, 0, 0);
    add(OP_STEP, 0, 16'h0000, 0, 0, 2, 16'h0000, 16'h0000, 0, 0, 0, 1);
    add(OP_IDLE, 0, 16'h0000, 0, 0, 0, 16'h0022, 16'h0007, 0, 0, 0, 1);
    // births fed from the west input only
    add(OP_RST,  0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0);
    add(OP_STEP, 0, 16'h0000, 0, 2, 0, 16'h0002, 16'h0000, 0, 0, 0, 1);
    add(OP_STEP, 0, 16'h0000, 0, 2, 0, 16'h0007, 16'h0002, 0, 0, 0, 2);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    foreach (vecs[i]) apply_vec(i, vecs[i]);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    // edge outputs after the column-0 blinker flips, wrap on then off
    reset_a();
    write_a(2'd0, 16'h0007, 1'b1);
    step_a_once(1'b1, 2'd0);
    check("wrap w_out", 32'(w_out_a), 32'h02);
    check("wrap e_out", 32'(e_out_a), 32'h02);
    check("wrap n_out", 32'(n_out_a), 32'h00);
    check("wrap s_out", 32'(s_out_a), 32'h00);
    reset_a();
    write_a(2'd0, 16'h0007, 1'b0);
    step_a_once(1'b0, 2'd0);
    check("bound w_out", 32'(w_out_a), 32'h02);
    check("bound e_out", 32'(e_out_a), 32'h00);

    // 12x8: out-of-range tile write is ignored and reads as zero
    @(negedge clk);
    check("b reset gen", 32'(gen_b), 32'h0);
    check("b reset extinct", 32'(ext_b), 32'h1);
    wsel_b = 3'd6; vali_b = 16'hFFFF; we_b = 1'b1;
    @(posedge clk);
    #1 we_b = 1'b0;
    for (int t = 6; t < 8; t++) begin
      rsel_b = 3'(t);
      #1;
      check($sformatf("b oor valo t%0d", t), 32'(valo_b), 32'h0);
      check($sformatf("b oor valo_prev t%0d", t), 32'(valo_prev_b), 32'h0);
    end
    check_all_tiles_b_zero("b oor");
    check("b oor extinct", 32'(ext_b), 32'h1);

    // 17 steps on a 4-bit counter wraps to 1
    @(negedge clk);
    step_b = 1'b1;
    repeat (17) @(posedge clk);
    #1 step_b = 1'b0;
    check("b gen wrap", 32'(gen_b), 32'h1);
    check("b empty stable", 32'(stable_b), 32'h1);
    check("b empty extinct", 32'(ext_b), 32'h1);

    // full tile 5, one step, then reset while step is still high
    @(negedge clk);
    wsel_b = 3'd5; vali_b = 16'hFFFF; we_b = 1'b1;
    @(posedge clk);
    #1 we_b = 1'b0;
    rsel_b = 3'd5;
    #1;
    check("b t5 write valo", 32'(valo_b), 32'hFFFF);
    check("b t5 write prev", 32'(valo_prev_b), 32'hFFFF);
    check("b t5 write gen", 32'(gen_b), 32'h0);
    check("b t5 write extinct", 32'(ext_b), 32'h0);
    rsel_b = 3'd4;
    #1;
    check("b t4 untouched", 32'(valo_b), 32'h0);
    @(negedge clk);
    step_b = 1'b1;
    @(posedge clk);
    #1 rsel_b = 3'd5;
    #1;
    check("b t5 step valo", 32'(valo_b), 32'h9009);
    check("b t5 step prev", 32'(valo_prev_b), 32'hFFFF);
    check("b t5 step gen", 32'(gen_b), 32'h1);
    @(posedge clk);
    #2 rst_b = 1'b1;
    #1;
    check("b midreset gen", 32'(gen_b), 32'h0);
    check("b midreset extinct", 32'(ext_b), 32'h1);
    check("b midreset stable", 32'(stable_b), 32'h0);
    check("b midreset osc", 32'(osc_b), 32'h0);
    check_all_tiles_b_zero("b midreset");
    @(negedge clk);
    rst_b = 1'b0; step_b = 1'b0;
    repeat (2) @(posedge clk);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
